// File: rtl/sine_nco_if.sv
// ---------------------------------------------------------------------------
// sine_nco_if -- signal bundle between the NCO, the sine ROM and the codec
// side. Clock and reset are not part of the bundle.
//
//   i_en            oscillator enable (low = synchronous clear)
//   i_fcw           frequency control word, added to phase once per sample
//   i_wave_sel      0 sine, 1 square, 2 sawtooth, 3 triangle
//   i_sample_req    single-cycle sample request
//   o_lut_addr      registered ROM address (top bits of phase)
//   i_lut_data      ROM read data, combinational from o_lut_addr
//   o_sample        output sample, two's complement
//   o_sample_valid  o_sample valid
//   i_sample_ready  consumer accepts sample
//   o_busy          oscillator is fetching or holding a sample
//   o_overrun       sticky: a request arrived while busy
//
// Modports: slave = the NCO itself, master = the surrounding system.
// ---------------------------------------------------------------------------
interface sine_nco_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
);
  logic               i_en;
  logic [PHASE_W-1:0] i_fcw;
  logic [1:0]         i_wave_sel;
  logic               i_sample_req;
  logic [ADDR_W-1:0]  o_lut_addr;
  logic [DATA_W-1:0]  i_lut_data;
  logic [DATA_W-1:0]  o_sample;
  logic               o_sample_valid;
  logic               i_sample_ready;
  logic               o_busy;
  logic               o_overrun;

  modport slave (
    input  i_en, i_fcw, i_wave_sel, i_sample_req, i_lut_data, i_sample_ready,
    output o_lut_addr, o_sample, o_sample_valid, o_busy, o_overrun
  );

  modport master (
    output i_en, i_fcw, i_wave_sel, i_sample_req, i_lut_data, i_sample_ready,
    input  o_lut_addr, o_sample, o_sample_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/sine_nco.sv
// ---------------------------------------------------------------------------
// sine_nco -- numerically controlled oscillator feeding the audio codec.
//
// Each sample request runs IDLE -> FETCH -> HOLD. In FETCH the sample is
// built from the pre-increment phase (sine from the external ROM, the other
// waveforms straight from phase bits) and the phase advances by i_fcw. HOLD
// presents the sample on a valid/ready handshake until the consumer accepts.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      sine_nco_if.slave (control, ROM bus, sample handshake, status)
// ---------------------------------------------------------------------------
module sine_nco #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  sine_nco_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [1:0] SEL_SINE   = 2'd0;
  localparam logic [1:0] SEL_SQUARE = 2'd1;
  localparam logic [1:0] SEL_SAW    = 2'd2;

  // Full-scale levels; the negative one is symmetric (-max, not -max-1).
  localparam logic [DATA_W-1:0] POS_FULL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_FULL = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MSB_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]         state_q,   state_d;
  logic [PHASE_W-1:0] phase_q,   phase_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  sample_q,  sample_d;
  logic               overrun_q, overrun_d;

  logic [PHASE_W-1:0] phase_inc;
  logic [DATA_W-1:0]  tri_mag;
  logic [DATA_W-1:0]  wave;

  assign phase_inc = phase_q + bus.i_fcw;

  // Triangle: fold the second half of the cycle by inverting the ramp taken
  // one bit below the phase MSB, so it rises then falls over a full period.
  assign tri_mag = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2 -: DATA_W]
                                      :  phase_q[PHASE_W-2 -: DATA_W];

  always_comb begin
    unique case (bus.i_wave_sel)
      SEL_SINE:   wave = bus.i_lut_data;
      SEL_SQUARE: wave = phase_q[PHASE_W-1] ? NEG_FULL : POS_FULL;
      // Offset-binary ramp to two's complement by flipping the MSB.
      SEL_SAW:    wave = phase_q[PHASE_W-1 -: DATA_W] ^ MSB_FLIP;
      default:    wave = tri_mag ^ MSB_FLIP;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so branches
    // that do not assign it cannot infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;

    if (!bus.i_en) begin
      // Disable clears everything except the last sample, which the codec
      // may still be shifting out.
      state_d   = IDLE;
      phase_d   = '0;
      addr_d    = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_sample_req) state_d = FETCH;
        end
        FETCH: begin
          sample_d = wave;
          phase_d  = phase_inc;
          // Address follows the new phase so the ROM output has settled
          // long before the next FETCH looks at it.
          addr_d   = phase_inc[PHASE_W-1 -: ADDR_W];
          state_d  = HOLD;
          if (bus.i_sample_req) overrun_d = 1'b1;
        end
        HOLD: begin
          // A request in the cycle the handshake completes is still an
          // overrun; requests are never queued.
          if (bus.i_sample_req)   overrun_d = 1'b1;
          if (bus.i_sample_ready) state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      addr_q    <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q   <= state_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  end

  // Valid is decoded from the state register, so an asynchronous reset
  // during HOLD drops it immediately.
  assign bus.o_lut_addr     = addr_q;
  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = (state_q == HOLD);
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_overrun      = overrun_q;

endmodule

// File: doc/sine_nco.md
# sine_nco

Numerically controlled oscillator that reads the 1024-entry sine lookup ROM and produces one 16-bit two's-complement audio sample per request. It sits between the audio codec serializer (WM8731 path) and the sine ROM. On each sample request it drives the ROM address from a 32-bit phase accumulator and registers the returned word. It can also synthesize square, sawtooth and triangle waves directly from the phase. Output is presented on a valid/ready handshake.

## Interface
- PHASE_W, 32, phase accumulator width
- ADDR_W, 10, ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
- DATA_W, 16, sample width (two's complement)
- i_clk  in  1  single clock; all logic rising-edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_en  in  1  oscillator enable; low = synchronous clear of phase/FSM/flags
- i_fcw  in  PHASE_W  frequency control word, added to phase once per sample
- i_wave_sel  in  2  0 sine, 1 square, 2 sawtooth, 3 triangle
- i_sample_req  in  1  single-cycle sample request from codec side
- o_lut_addr  out  ADDR_W  ROM address (registered)
- i_lut_data  in  DATA_W  ROM read data, combinational from o_lut_addr
- o_sample  out  DATA_W  output sample
- o_sample_valid  out  1  o_sample valid
- i_sample_ready  in  1  consumer accepts sample
- o_busy  out  1  FSM not in IDLE
- o_overrun  out  1  sticky: request arrived while busy

## Operation
- State: phase register P (PHASE_W), o_lut_addr = P[31:22] registered from P.
- FSM states IDLE, FETCH, HOLD.
- IDLE: i_en && i_sample_req -> FETCH. Otherwise stay.
- FETCH (one cycle): capture o_sample from the current P and i_wave_sel; P <= P + i_fcw (mod 2^32, wrap silent); i_fcw and i_wave_sel sampled this cycle only; -> HOLD with o_sample_valid=1.
- HOLD: o_sample and o_sample_valid held stable; i_sample_ready=1 -> valid drops next cycle, -> IDLE.
- Waveform, from pre-increment P:
  - sine: i_lut_data unchanged (ROM holds two's-complement words)
  - square: P[31]==0 ? 16'h7FFF : 16'h8001
  - sawtooth: P[31:16] ^ 16'h8000
  - triangle: t = P[31] ? ~P[30:15] : P[30:15]; sample = t ^ 16'h8000
- i_sample_req while FETCH or HOLD: ignored, o_overrun set (sticky).
- i_sample_req in the same cycle HOLD completes (ready=1): counts as overrun, not queued.
- i_en low (any state): next cycle FSM=IDLE, P=0, o_lut_addr=0, o_sample_valid=0, o_overrun=0; o_sample keeps its last value.
- Reset values: P=0, FSM=IDLE, o_lut_addr=0, o_sample=0, o_sample_valid=0, o_busy=0, o_overrun=0.
- Reset asserted mid-HOLD: valid drops immediately (asynchronous), no sample delivered.

## Timing
- Request seen in IDLE at edge N -> FETCH during cycle N+1 -> o_sample_valid=1 from cycle N+2.
- o_lut_addr reflects the updated phase from cycle N+2 onward, so the ROM output has settled before the next FETCH.
- Minimum request spacing without overrun is 3 cycles with ready held high.
- o_busy = 1 during FETCH and HOLD.
- ROM is combinational. No wait state is needed between address and data.

## Test plan
- Reset: hold i_rst_n=0 for 5 cycles, then release -> all outputs 0, FSM IDLE; request 2 cycles later -> valid at req+2.
- Sine stepping: fcw=32'h0040_0000, ready tied 1, 4 requests spaced 4 cycles -> o_lut_addr 0,1,2,3,4; samples = ROM[0..3]; each valid exactly 1 cycle.
- Square/wrap: fcw=32'h8000_0000, sel=1, 4 requests -> samples 7FFF,8001,7FFF,8001; address alternates 0,512.
- Saw and triangle: sel=2, fcw=32'h1000_0000 -> 8000,9000,A000,...,7000 then wraps to 8000. sel=3, fcw=32'h2000_0000 -> 8000,C000,0000,4000,7FFF,3FFF,FFFF,BFFF.
- Backpressure/overrun: ready=0 for 6 cycles after valid, with a second request during HOLD -> o_sample stable and o_overrun=1. Ready=1 -> valid drops next cycle. The ignored request produces no sample.
- Disable mid-operation: drop i_en in HOLD -> next cycle valid=0, addr=0, overrun=0. Re-enable and request -> first sample uses phase 0.
